dmem_lsu: RTL and testbench

Load/store unit between the CPU's memory-stage control and the word-organised data memory (11-bit word address, asynchronous read, write committed on the falling clock edge while write-enable is high). Accepts byte, halfword and word loads and stores on 32-bit byte addresses. Performs lane extraction with sign or zero extension on loads, and read-modify-write for sub-word stores. Stalls the CPU through a valid/ready handshake while a multi-cycle access is in progress.

---
 rtl/dmem_lsu.sv | 143 ++++++++++++++
 tb/tb_dmem_lsu.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// ============================================================================
// dmem_lsu : load/store unit with lane extract/extend and sub-word RMW stores
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_lsu #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy,
  output logic              mem_wena,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RMW_RD = 3'd2,
    S_STORE  = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          size_q;
  logic                signed_q;
  logic [1:0]          off_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         old_q;
  logic [31:0]         rdata_q;
  logic                err_q;

  logic                accept;
  logic                req_err;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [31:0]         ld_val;
  logic [31:0]         merged;

  // Byte address bits above the word address are intentionally discarded.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  assign accept  = req_valid && (state_q == S_IDLE);
  assign req_err = (req_size == 2'b11) ||
                   ((req_size == 2'b01) && req_addr[0]) ||
                   ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_err)                 state_d = S_RESP;
          else if (!req_we)            state_d = S_LOAD;
          else if (req_size == 2'b10)  state_d = S_STORE;
          else                         state_d = S_RMW_RD;
        end
      end
      S_LOAD:   state_d = S_RESP;
      S_RMW_RD: state_d = S_STORE;
      S_STORE:  state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ld_byte = mem_rdata[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   ld_val = {{24{signed_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_val = {{16{signed_q & ld_half[15]}}, ld_half};
      default: ld_val = mem_rdata;
    endcase
  end

  // Sub-word stores splice the new lane(s) into the word captured in RMW_RD.
  always_comb begin
    merged = old_q;
    case (size_q)
      2'b00: merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
      2'b01: begin
        if (off_q[1]) merged[31:16] = wdata_q[15:0];
        else          merged[15:0]  = wdata_q[15:0];
      end
      default: merged = wdata_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      off_q    <= 2'b00;
      waddr_q  <= '0;
      wdata_q  <= '0;
      old_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        size_q   <= req_size;
        signed_q <= req_signed;
        off_q    <= req_addr[1:0];
        waddr_q  <= req_addr[ADDR_W+1:2];
        wdata_q  <= req_wdata;
        rdata_q  <= '0;
        err_q    <= req_err;
      end
      if (state_q == S_LOAD)   rdata_q <= ld_val;
      if (state_q == S_RMW_RD) old_q   <= mem_rdata;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = !req_ready;
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_wena   = (state_q == S_STORE) && !rst;
  assign mem_addr   = waddr_q;
  assign mem_wdata  = (state_q == S_STORE) ? merged : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_dmem_lsu.sv
// ============================================================================
// tb_dmem_lsu : table vectors, corner sequences and randomized model checks
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_lsu;

  localparam int ADDR_W = 11;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              busy;
  logic              mem_wena;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic [7:0]  refmem [0:(4<<ADDR_W)-1];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_lsu #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .busy(busy), .mem_wena(mem_wena),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];
  always @(negedge clk) if (mem_wena) mem[mem_addr] <= mem_wdata;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from an IDLE cycle and follow it through its response.
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int wcnt, output logic [31:0] waddr, output int bcnt);
    bit done;
    rdata = '0; err = 1'b0; lat = 0; wcnt = 0; waddr = '0; bcnt = 0; done = 0;
    chk("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int c = 1; c <= 8 && !done; c++) begin
      if (mem_wena) begin wcnt++; waddr = {21'd0, mem_addr}; end
      if (busy) bcnt++;
      if (resp_valid) begin
        lat = c; rdata = resp_rdata; err = resp_err; done = 1;
      end
      step();
    end
    if (!done) chk("resp_timeout", 32'd0, 32'd1);
  endtask

  // Reference: byte-addressed memory, sizes as byte counts, plain arithmetic.
  task automatic ref_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] exp_rdata, output logic exp_err, output int exp_lat);
    int n, base;
    longint v;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    base = int'(addr % (4 << ADDR_W));
    exp_rdata = '0;
    exp_err = (size == 2'd3) || ((addr % n) != 0);
    if (exp_err) begin
      exp_lat = 1;
    end else if (!we) begin
      v = 0;
      for (int k = 0; k < n; k++) v = v + (longint'(refmem[base+k]) << (8*k));
      if (sgn && v[8*n-1]) v = v - (longint'(1) << (8*n));
      exp_rdata = v[31:0];
      exp_lat = 2;
    end else begin
      for (int k = 0; k < n; k++) refmem[base+k] = 8'((wdata >> (8*k)) & 32'hFF);
      exp_lat = (n == 4) ? 2 : 3;
    end
  endtask

  logic [31:0] r_data, r_waddr, e_data, word_exp;
  logic        r_err, e_err;
  int          r_lat, r_wcnt, r_bcnt, e_lat, e_wcnt;

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    step(); step();
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err",   {31'd0, resp_err}, 32'd0);
    chk("rst_mem_wena",   {31'd0, mem_wena}, 32'd0);
    chk("rst_mem_addr",   {21'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata",  mem_wdata, 32'd0);
    rst = 1'b0;
    step();
    chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2};
    tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2};
    tbl[2]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF7F01, 32'h0,        1'b0, 2};
    tbl[3]  = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        32'hFFFFFF80, 1'b0, 2};
    tbl[4]  = '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        32'h00000080, 1'b0, 2};
    tbl[5]  = '{1'b0, 2'd0, 1'b1, 32'h10, 32'h0,        32'h00000001, 1'b0, 2};
    tbl[6]  = '{1'b0, 2'd1, 1'b1, 32'h12, 32'h0,        32'hFFFF80FF, 1'b0, 2};
    tbl[7]  = '{1'b0, 2'd1, 1'b0, 32'h10, 32'h0,        32'h00007F01, 1'b0, 2};
    tbl[8]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 32'h0,        1'b0, 2};
    tbl[9]  = '{1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFFFFAA, 32'h0,        1'b0, 3};
    tbl[10] = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h1122AA44, 1'b0, 2};
    tbl[11] = '{1'b1, 2'd1, 1'b0, 32'h12, 32'h0000BEEF, 32'h0,        1'b0, 3};
    tbl[12] = '{1'b0, 2'd1, 1'b1, 32'h11, 32'h0,        32'h0,        1'b1, 1};
    tbl[13] = '{1'b1, 2'd2, 1'b0, 32'h12, 32'h55555555, 32'h0,        1'b1, 1};
    tbl[14] = '{1'b1, 2'd3, 1'b0, 32'h10, 32'h66666666, 32'h0,        1'b1, 1};
    tbl[15] = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hBEEFAA44, 1'b0, 2};

    for (int i = 0; i < 16; i++) begin
      do_req(tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata,
             r_data, r_err, r_lat, r_wcnt, r_waddr, r_bcnt);
      e_wcnt = (tbl[i].we && !tbl[i].exp_err) ? 1 : 0;
      chk($sformatf("tbl%0d_rdata", i), r_data, tbl[i].exp_rdata);
      chk($sformatf("tbl%0d_err", i), {31'd0, r_err}, {31'd0, tbl[i].exp_err});
      chk($sformatf("tbl%0d_lat", i), r_lat, tbl[i].exp_lat);
      chk($sformatf("tbl%0d_busy", i), r_bcnt, tbl[i].exp_lat);
      chk($sformatf("tbl%0d_wena", i), r_wcnt, e_wcnt);
      if (e_wcnt != 0) chk($sformatf("tbl%0d_waddr", i), r_waddr, 32'd4);
    end
    chk("word4_after_errs", mem[4], 32'hBEEFAA44);

    // Reset while the write of a byte store is pending.
    req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0; req_addr = 32'h20; req_wdata = 32'h55;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk("rststore_busy", {31'd0, busy}, 32'd1);
    step();
    rst = 1'b1;
    #1;
    chk("rststore_wena", {31'd0, mem_wena}, 32'd0);
    step();
    rst = 1'b0;
    chk("rststore_no_resp", {31'd0, resp_valid}, 32'd0);
    chk("rststore_ready", {31'd0, req_ready}, 32'd1);
    step();
    chk("rststore_no_resp2", {31'd0, resp_valid}, 32'd0);
    chk("rststore_word8", mem[8], 32'h0);

    // Wrapped word store followed by a held load request.
    req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h2000; req_wdata = 32'h12345678;
    req_valid = 1'b1;
    step();
    chk("b2b_store_wena", {31'd0, mem_wena}, 32'd1);
    chk("b2b_store_addr", {21'd0, mem_addr}, 32'd0);
    req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    step();
    chk("b2b_store_resp", {31'd0, resp_valid}, 32'd1);
    step();
    chk("b2b_idle_ready", {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
    chk("b2b_load_busy", {31'd0, busy}, 32'd1);
    step();
    chk("b2b_load_resp", {31'd0, resp_valid}, 32'd1);
    chk("b2b_load_data", resp_rdata, 32'h12345678);
    step();

    for (int i = 0; i < (1 << ADDR_W); i++)
      for (int k = 0; k < 4; k++) refmem[4*i+k] = mem[i][8*k +: 8];

    for (int i = 0; i < 300; i++) begin
      logic        we, sgn;
      logic [1:0]  size;
      logic [31:0] addr, wdata;
      we    = 1'($urandom_range(0, 1));
      sgn   = 1'($urandom_range(0, 1));
      size  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      addr  = $urandom;
      addr[12:6] = 7'd0;
      if ($urandom_range(0, 3) != 0) begin
        if (size == 2'd1) addr[0] = 1'b0;
        if (size == 2'd2) addr[1:0] = 2'b00;
      end
      wdata = $urandom;
      ref_req(we, size, sgn, addr, wdata, e_data, e_err, e_lat);
      do_req(we, size, sgn, addr, wdata, r_data, r_err, r_lat, r_wcnt, r_waddr, r_bcnt);
      e_wcnt = (we && !e_err) ? 1 : 0;
      chk($sformatf("rnd%0d_rdata", i), r_data, e_data);
      chk($sformatf("rnd%0d_err", i), {31'd0, r_err}, {31'd0, e_err});
      chk($sformatf("rnd%0d_lat", i), r_lat, e_lat);
      chk($sformatf("rnd%0d_wena", i), r_wcnt, e_wcnt);
      word_exp = {refmem[{addr[12:2], 2'd3}], refmem[{addr[12:2], 2'd2}],
                  refmem[{addr[12:2], 2'd1}], refmem[{addr[12:2], 2'd0}]};
      chk($sformatf("rnd%0d_word", i), mem[addr[12:2]], word_exp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
